fcmp_pipe: RTL

// - Pipelined, multi-mode comparator for FloPoCo-format floats {exc[1:0], sign, exp[WE-1:0], frac[WF-1:0]}.
// - Replaces single-mode combinational less-than cores in HLS datapaths.
// - Runtime op select: LT, LE, EQ, NE, GT, GE, MIN, MAX.
// - Valid/ready streaming with backpressure; carries a tag alongside each operation.

---
 rtl/fcmp_pkg.sv | 44 ++++
 rtl/fcmp_classify.sv | 32 +++
 rtl/fcmp_pipe.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/fcmp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fcmp_pkg: shared types and helpers for the fcmp_pipe comparator.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package fcmp_pkg;

  typedef enum logic [1:0] {
    ZERO   = 2'b00,
    NORMAL = 2'b01,
    INF    = 2'b10,
    NAN    = 2'b11
  } exc_t;

  typedef enum logic [2:0] {
    OP_LT  = 3'd0,
    OP_LE  = 3'd1,
    OP_EQ  = 3'd2,
    OP_NE  = 3'd3,
    OP_GT  = 3'd4,
    OP_GE  = 3'd5,
    OP_MIN = 3'd6,
    OP_MAX = 3'd7
  } fcmp_op_t;

  typedef struct packed {
    logic zero;
    logic normal;
    logic inf;
    logic nan;
    logic sign;
  } cls_t;

  function automatic int fp_width(input int we, input int wf);
    return we + wf + 3;
  endfunction

  // Canonical NaN {2'b11, zeros}, right-aligned to an operand of width w.
  function automatic logic [63:0] canon_nan(input int w);
    return {62'd0, NAN} << (w - 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fcmp_classify.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fcmp_classify: decodes one FloPoCo operand into class, sign, {e,f}.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fcmp_classify
  import fcmp_pkg::*;
#(
  parameter int WE = 5,
  parameter int WF = 5
) (
  input  logic [WE+WF+2:0] x,
  output logic             is_zero,
  output logic             is_normal,
  output logic             is_inf,
  output logic             is_nan,
  output logic             sign,
  output logic [WE+WF-1:0] mag
);

  exc_t exc;

  assign exc       = exc_t'(x[WE+WF+2 -: 2]);
  assign is_zero   = (exc == ZERO);
  assign is_normal = (exc == NORMAL);
  assign is_inf    = (exc == INF);
  assign is_nan    = (exc == NAN);
  assign sign      = x[WE+WF];
  assign mag       = x[WE+WF-1:0];

endmodule
`default_nettype wire

// File: rtl/fcmp_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fcmp_pipe: two-stage multi-mode float comparator, valid/ready stream.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fcmp_pipe
  import fcmp_pkg::*;
#(
  parameter int WE    = 5,
  parameter int WF    = 5,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WE+WF+2:0] in_x,
  input  logic [WE+WF+2:0] in_y,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_flag,
  output logic [WE+WF+2:0] out_value,
  output logic             out_unord,
  output logic [TAG_W-1:0] out_tag
);

  localparam int            W         = fp_width(WE, WF);
  localparam logic [W-1:0]  CANON_NAN = W'(canon_nan(W));

  cls_t               x_cls, y_cls;
  logic [WE+WF-1:0]   x_mag, y_mag;

  fcmp_classify #(.WE(WE), .WF(WF)) u_cls_x (
    .x(in_x), .is_zero(x_cls.zero), .is_normal(x_cls.normal), .is_inf(x_cls.inf),
    .is_nan(x_cls.nan), .sign(x_cls.sign), .mag(x_mag)
  );

  fcmp_classify #(.WE(WE), .WF(WF)) u_cls_y (
    .x(in_y), .is_zero(y_cls.zero), .is_normal(y_cls.normal), .is_inf(y_cls.inf),
    .is_nan(y_cls.nan), .sign(y_cls.sign), .mag(y_mag)
  );

  logic             advance;
  logic             s1_valid, s2_valid;
  cls_t             s1_xc, s1_yc;
  logic             s1_mag_lt, s1_mag_gt;
  fcmp_op_t         s1_op;
  logic [TAG_W-1:0] s1_tag;
  logic [W-1:0]     s1_x, s1_y;

  logic             lt, gt, eq, unord;
  logic             d_flag;
  logic [W-1:0]     d_value;

  // Numeric a < b for non-NaN operands; ab_lt/ab_gt are the {exp,frac} compares.
  function automatic logic lt_fn(input cls_t a, input cls_t b, input logic ab_lt,
                                 input logic ab_gt);
    if (a.inf)                 return a.sign && !(b.inf && b.sign);
    else if (b.inf)            return !b.sign;
    else if (a.zero && b.zero) return 1'b0;
    else if (a.zero)           return !b.sign;
    else if (b.zero)           return a.sign;
    else if (a.sign != b.sign) return a.sign;
    else                       return a.sign ? ab_gt : ab_lt;
  endfunction

  always_comb begin
    lt      = lt_fn(s1_xc, s1_yc, s1_mag_lt, s1_mag_gt);
    gt      = lt_fn(s1_yc, s1_xc, s1_mag_gt, s1_mag_lt);
    eq      = (s1_xc.zero && s1_yc.zero)
            || (s1_xc.inf && s1_yc.inf && (s1_xc.sign == s1_yc.sign))
            || (s1_xc.normal && s1_yc.normal && (s1_xc.sign == s1_yc.sign)
                && !s1_mag_lt && !s1_mag_gt);
    unord   = s1_xc.nan || s1_yc.nan;
    d_flag  = 1'b0;
    d_value = '0;
    case (s1_op)
      OP_LT:  d_flag = lt && !unord;
      OP_LE:  d_flag = (lt || eq) && !unord;
      OP_EQ:  d_flag = eq && !unord;
      OP_NE:  d_flag = !eq || unord;
      OP_GT:  d_flag = gt && !unord;
      OP_GE:  d_flag = (gt || eq) && !unord;
      OP_MIN: begin
        if (s1_xc.nan && s1_yc.nan) d_value = CANON_NAN;
        else if (s1_xc.nan)         d_value = s1_y;
        else if (s1_yc.nan)         d_value = s1_x;
        else                        d_value = gt ? s1_y : s1_x;
      end
      OP_MAX: begin
        if (s1_xc.nan && s1_yc.nan) d_value = CANON_NAN;
        else if (s1_xc.nan)         d_value = s1_y;
        else if (s1_yc.nan)         d_value = s1_x;
        else                        d_value = lt ? s1_y : s1_x;
      end
      default: ;
    endcase
  end

  // Whole pipe moves together; a full output stage blocks everything upstream.
  assign advance   = !s2_valid || out_ready;
  assign in_ready  = advance;
  assign out_valid = s2_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_xc     <= '0;
      s1_yc     <= '0;
      s1_mag_lt <= 1'b0;
      s1_mag_gt <= 1'b0;
      s1_op     <= OP_LT;
      s1_tag    <= '0;
      s1_x      <= '0;
      s1_y      <= '0;
      s2_valid  <= 1'b0;
      out_flag  <= 1'b0;
      out_value <= '0;
      out_unord <= 1'b0;
      out_tag   <= '0;
    end else if (advance) begin
      s1_valid  <= in_valid;
      s1_xc     <= x_cls;
      s1_yc     <= y_cls;
      s1_mag_lt <= (x_mag < y_mag);
      s1_mag_gt <= (x_mag > y_mag);
      s1_op     <= fcmp_op_t'(in_op);
      s1_tag    <= in_tag;
      s1_x      <= in_x;
      s1_y      <= in_y;
      s2_valid  <= s1_valid;
      out_flag  <= d_flag;
      out_value <= d_value;
      out_unord <= unord;
      out_tag   <= s1_tag;
    end
  end

endmodule
`default_nettype wire
